// File: rtl/map_table_pkg.sv
// rtl/map_table_pkg.sv - shared processor constants and operand types for register renaming
package map_table_pkg;

    localparam int PR_W   = 6;
    localparam int ARCH_N = 32;
    localparam int WAYS   = 3;
    localparam int ARCH_W = $clog2(ARCH_N);
    localparam int NUM_PR = 1 << PR_W;

    typedef logic [PR_W-1:0]   preg_t;
    typedef logic [ARCH_W-1:0] arch_t;

endpackage

// File: rtl/map_table_arch_map.sv
// rtl/map_table_arch_map.sv - architectural (retirement) map with exposed next-state array
module arch_map #(
    parameter int PR_W   = map_table_pkg::PR_W,
    parameter int ARCH_N = map_table_pkg::ARCH_N,
    parameter int WAYS   = map_table_pkg::WAYS,
    localparam int ARCH_W = $clog2(ARCH_N)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WAYS-1:0]                   retire_en_i,
    input  logic [WAYS-1:0][ARCH_W-1:0]       retire_arch_i,
    input  logic [WAYS-1:0][PR_W-1:0]         retire_preg_i,
    output logic [ARCH_N-1:0][PR_W-1:0]       map_d_o
);

    logic [ARCH_N-1:0][PR_W-1:0] map_q;
    logic [ARCH_N-1:0][PR_W-1:0] map_d;

    // Apply retirements oldest way first so the youngest way wins a shared arch reg; r0 stays PR 0
    always_comb begin
        map_d = map_q;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (retire_en_i[k] && (retire_arch_i[k] != '0)) begin
                map_d[retire_arch_i[k]] = retire_preg_i[k];
            end
        end
        map_d[0] = '0;
    end

    // Committed map register; reset restores the identity mapping
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_N; i++) begin
                map_q[i] <= PR_W'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    assign map_d_o = map_d;

endmodule

// File: rtl/map_table.sv
// rtl/map_table.sv - speculative rename map with ready bits, intra-group bypass and recovery
module map_table #(
    parameter int PR_W   = map_table_pkg::PR_W,
    parameter int ARCH_N = map_table_pkg::ARCH_N,
    parameter int WAYS   = map_table_pkg::WAYS,
    localparam int ARCH_W = $clog2(ARCH_N),
    localparam int NUM_PR = 1 << PR_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WAYS-1:0]             dispatch_en,
    input  logic [WAYS-1:0]             dest_valid,
    input  logic [WAYS-1:0][ARCH_W-1:0] dest_arch,
    input  logic [WAYS-1:0][ARCH_W-1:0] src1_arch,
    input  logic [WAYS-1:0][ARCH_W-1:0] src2_arch,
    input  logic [WAYS-1:0][PR_W-1:0]   free_reg,
    input  logic [WAYS-1:0]             free_reg_valid,
    input  logic [WAYS-1:0]             cdb_valid,
    input  logic [WAYS-1:0][PR_W-1:0]   cdb_tag,
    input  logic [WAYS-1:0]             retire_en,
    input  logic [WAYS-1:0][ARCH_W-1:0] retire_arch,
    input  logic [WAYS-1:0][PR_W-1:0]   retire_preg,
    input  logic                        bp_recover_en,
    output logic [WAYS-1:0][PR_W-1:0]   src1_preg,
    output logic [WAYS-1:0][PR_W-1:0]   src2_preg,
    output logic [WAYS-1:0]             src1_ready,
    output logic [WAYS-1:0]             src2_ready,
    output logic [WAYS-1:0][PR_W-1:0]   told,
    output logic                        rename_ok
);

    logic [ARCH_N-1:0][PR_W-1:0] spec_map_q;
    logic [ARCH_N-1:0][PR_W-1:0] spec_map_d;
    logic [NUM_PR-1:0]           ready_q;
    logic [NUM_PR-1:0]           ready_d;
    logic [ARCH_N-1:0][PR_W-1:0] arch_map_next;
    logic [WAYS-1:0]             need_pr;

    // Returns {ready, preg} for arch reg `arch` as seen by way k. Older ways (j > k) renaming the
    // same arch reg this cycle take priority, the nearest older one winning; such a value is never
    // ready. Otherwise the stored mapping is used, with a same-cycle CDB tag forcing ready.
    function automatic logic [PR_W:0] lookup(
        input logic [ARCH_W-1:0]             arch,
        input int                            k,
        input logic [WAYS-1:0]               need,
        input logic [WAYS-1:0][ARCH_W-1:0]   darch,
        input logic [WAYS-1:0][PR_W-1:0]     fregs,
        input logic [ARCH_N-1:0][PR_W-1:0]   map,
        input logic [NUM_PR-1:0]             rdy,
        input logic [WAYS-1:0]               cvalid,
        input logic [WAYS-1:0][PR_W-1:0]     ctag
    );
        logic [PR_W-1:0] preg;
        logic            ready;
        logic            bypassed;
        preg     = map[arch];
        bypassed = 1'b0;
        for (int j = WAYS - 1; j >= 0; j--) begin
            if ((j > k) && need[j] && (darch[j] == arch)) begin
                preg     = fregs[j];
                bypassed = 1'b1;
            end
        end
        if (bypassed) begin
            ready = 1'b0;
        end else begin
            ready = (arch == '0) || rdy[preg];
            for (int j = 0; j < WAYS; j++) begin
                if (cvalid[j] && (ctag[j] == preg)) begin
                    ready = 1'b1;
                end
            end
        end
        return {ready, preg};
    endfunction

    arch_map #(
        .PR_W   (PR_W),
        .ARCH_N (ARCH_N),
        .WAYS   (WAYS)
    ) u_arch_map (
        .clock         (clock),
        .reset         (reset),
        .retire_en_i   (retire_en),
        .retire_arch_i (retire_arch),
        .retire_preg_i (retire_preg),
        .map_d_o       (arch_map_next)
    );

    // Decide which ways allocate a PR and whether the whole group can rename this cycle
    always_comb begin
        rename_ok = !bp_recover_en;
        for (int k = 0; k < WAYS; k++) begin
            need_pr[k] = dispatch_en[k] && dest_valid[k] && (dest_arch[k] != '0);
            if (need_pr[k] && !free_reg_valid[k]) begin
                rename_ok = 1'b0;
            end
        end
    end

    // Rename lookups for both sources and the previous destination mapping of every way
    always_comb begin
        logic [PR_W:0] res;
        for (int k = 0; k < WAYS; k++) begin
            res = lookup(src1_arch[k], k, need_pr, dest_arch, free_reg, spec_map_q, ready_q,
                         cdb_valid, cdb_tag);
            src1_preg[k]  = res[PR_W-1:0];
            src1_ready[k] = res[PR_W];
            res = lookup(src2_arch[k], k, need_pr, dest_arch, free_reg, spec_map_q, ready_q,
                         cdb_valid, cdb_tag);
            src2_preg[k]  = res[PR_W-1:0];
            src2_ready[k] = res[PR_W];
            res = lookup(dest_arch[k], k, need_pr, dest_arch, free_reg, spec_map_q, ready_q,
                         cdb_valid, cdb_tag);
            told[k] = need_pr[k] ? res[PR_W-1:0] : '0;
        end
    end

    // Speculative map next state: recovery copies the committed map, otherwise the youngest writer wins
    always_comb begin
        spec_map_d = spec_map_q;
        if (bp_recover_en) begin
            spec_map_d = arch_map_next;
        end else if (rename_ok) begin
            for (int k = WAYS - 1; k >= 0; k--) begin
                if (need_pr[k]) begin
                    spec_map_d[dest_arch[k]] = free_reg[k];
                end
            end
        end
        spec_map_d[0] = '0;
    end

    // Ready bits: CDB sets, a fresh allocation clears (and wins), recovery marks everything ready
    always_comb begin
        ready_d = ready_q;
        if (bp_recover_en) begin
            ready_d = '1;
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (cdb_valid[k]) begin
                    ready_d[cdb_tag[k]] = 1'b1;
                end
            end
            if (rename_ok) begin
                for (int k = 0; k < WAYS; k++) begin
                    if (need_pr[k]) begin
                        ready_d[free_reg[k]] = 1'b0;
                    end
                end
            end
        end
    end

    // State registers; reset forces the identity map and all PRs ready
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_N; i++) begin
                spec_map_q[i] <= PR_W'(i);
            end
            ready_q <= '1;
        end else begin
            spec_map_q <= spec_map_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_map_table.sv
// tb/tb_map_table.sv - randomized self-checking bench for map_table against a sequential rename model
module tb_map_table;
    import map_table_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                         reset;
    logic [WAYS-1:0]              dispatch_en, dest_valid, free_reg_valid, cdb_valid, retire_en;
    logic [WAYS-1:0][ARCH_W-1:0]  dest_arch, src1_arch, src2_arch, retire_arch;
    logic [WAYS-1:0][PR_W-1:0]    free_reg, cdb_tag, retire_preg;
    logic                         bp_recover_en;
    logic [WAYS-1:0][PR_W-1:0]    src1_preg, src2_preg, told;
    logic [WAYS-1:0]              src1_ready, src2_ready;
    logic                         rename_ok;

    map_table dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_en    (dispatch_en),
        .dest_valid     (dest_valid),
        .dest_arch      (dest_arch),
        .src1_arch      (src1_arch),
        .src2_arch      (src2_arch),
        .free_reg       (free_reg),
        .free_reg_valid (free_reg_valid),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .retire_en      (retire_en),
        .retire_arch    (retire_arch),
        .retire_preg    (retire_preg),
        .bp_recover_en  (bp_recover_en),
        .src1_preg      (src1_preg),
        .src2_preg      (src2_preg),
        .src1_ready     (src1_ready),
        .src2_ready     (src2_ready),
        .told           (told),
        .rename_ok      (rename_ok)
    );

    int checks = 0;
    int failures = 0;

    int m_spec[ARCH_N];
    int m_arch[ARCH_N];
    bit m_rdy[NUM_PR];
    int t_map[ARCH_N];
    int e_s1p[WAYS], e_s2p[WAYS], e_told[WAYS];
    bit e_s1r[WAYS], e_s2r[WAYS];
    bit e_ok;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit needs(input int k);
        return dispatch_en[k] && dest_valid[k] && (dest_arch[k] != 0);
    endfunction

    function automatic bit src_ready(input int a, input int p, input bit fresh);
        if (a == 0) return 1'b1;
        if (fresh) return 1'b0;
        if (m_rdy[p]) return 1'b1;
        for (int j = 0; j < WAYS; j++)
            if (cdb_valid[j] && (int'(cdb_tag[j]) == p)) return 1'b1;
        return 1'b0;
    endfunction

    // Rename the group one instruction at a time, oldest first, on a scratch copy of the map
    task automatic model_outputs();
        int tm[ARCH_N];
        bit fresh[ARCH_N];
        for (int a = 0; a < ARCH_N; a++) begin
            tm[a] = m_spec[a];
            fresh[a] = 1'b0;
        end
        e_ok = !bp_recover_en;
        for (int k = 0; k < WAYS; k++)
            if (needs(k) && !free_reg_valid[k]) e_ok = 1'b0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            int a1, a2, d;
            a1 = int'(src1_arch[k]);
            a2 = int'(src2_arch[k]);
            d  = int'(dest_arch[k]);
            e_s1p[k] = tm[a1];
            e_s1r[k] = src_ready(a1, tm[a1], fresh[a1]);
            e_s2p[k] = tm[a2];
            e_s2r[k] = src_ready(a2, tm[a2], fresh[a2]);
            if (needs(k)) begin
                e_told[k] = tm[d];
                tm[d] = int'(free_reg[k]);
                fresh[d] = 1'b1;
            end else begin
                e_told[k] = 0;
            end
        end
        t_map = tm;
    endtask

    task automatic model_update();
        if (!reset) begin
            for (int a = 0; a < ARCH_N; a++) begin
                m_spec[a] = a;
                m_arch[a] = a;
            end
            for (int p = 0; p < NUM_PR; p++) m_rdy[p] = 1'b1;
        end else begin
            for (int k = WAYS - 1; k >= 0; k--)
                if (retire_en[k] && retire_arch[k] != 0)
                    m_arch[retire_arch[k]] = int'(retire_preg[k]);
            if (bp_recover_en) begin
                m_spec = m_arch;
                for (int p = 0; p < NUM_PR; p++) m_rdy[p] = 1'b1;
            end else begin
                for (int k = 0; k < WAYS; k++)
                    if (cdb_valid[k]) m_rdy[cdb_tag[k]] = 1'b1;
                if (e_ok) begin
                    m_spec = t_map;
                    for (int k = 0; k < WAYS; k++)
                        if (needs(k)) m_rdy[free_reg[k]] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("rename_ok", rename_ok, e_ok);
        for (int k = 0; k < WAYS; k++) begin
            check_val($sformatf("src1_preg[%0d]", k), src1_preg[k], e_s1p[k]);
            check_val($sformatf("src1_ready[%0d]", k), src1_ready[k], e_s1r[k]);
            check_val($sformatf("src2_preg[%0d]", k), src2_preg[k], e_s2p[k]);
            check_val($sformatf("src2_ready[%0d]", k), src2_ready[k], e_s2r[k]);
            check_val($sformatf("told[%0d]", k), told[k], e_told[k]);
        end
    endtask

    task automatic cycle(input bit cmp);
        model_outputs();
        if (cmp) compare_all();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        reset = 1'b1;
        bp_recover_en = 1'b0;
        dispatch_en = '0; dest_valid = '0; free_reg_valid = '0;
        cdb_valid = '0; retire_en = '0;
        dest_arch = '0; src1_arch = '0; src2_arch = '0; retire_arch = '0;
        free_reg = '0; cdb_tag = '0; retire_preg = '0;
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 63) != 0);
        bp_recover_en = ($urandom_range(0, 15) == 0);
        dispatch_en = 3'($urandom);
        dest_valid = 3'($urandom);
        free_reg_valid = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
        cdb_valid = 3'($urandom);
        retire_en = 3'($urandom);
        for (int k = 0; k < WAYS; k++) begin
            dest_arch[k]   = 5'($urandom_range(0, 7));
            src1_arch[k]   = 5'($urandom_range(0, 8));
            src2_arch[k]   = 5'($urandom_range(0, 31));
            retire_arch[k] = 5'($urandom_range(0, 7));
            free_reg[k]    = 6'($urandom_range(1, 63));
            cdb_tag[k]     = 6'($urandom_range(0, 63));
            retire_preg[k] = 6'($urandom_range(1, 63));
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        @(negedge clock);
        #1;
        cycle(1'b0);

        // reset still asserted: identity lookups
        reset = 1'b0;
        src1_arch[2] = 5'd5;
        src2_arch[1] = 5'd17;
        #1;
        check_val("rst_src1_preg", src1_preg[2], 5);
        check_val("rst_src2_preg", src2_preg[1], 17);
        check_val("rst_src1_ready", src1_ready[2], 1);
        cycle(1'b1);

        // post-reset lookup with no dispatch
        clear_inputs();
        src1_arch[2] = 5'd5;
        #1;
        check_val("post_rst_preg", src1_preg[2], 5);
        check_val("post_rst_ready", src1_ready[2], 1);
        cycle(1'b1);

        // intra-group bypass and told
        clear_inputs();
        dispatch_en = 3'b111; dest_valid = 3'b101; free_reg_valid = 3'b111;
        dest_arch[2] = 5'd3; free_reg[2] = 6'd40;
        dest_arch[0] = 5'd3; free_reg[0] = 6'd41;
        src1_arch[1] = 5'd3;
        #1;
        check_val("byp_preg", src1_preg[1], 40);
        check_val("byp_ready", src1_ready[1], 0);
        check_val("told2", told[2], 3);
        check_val("told0", told[0], 40);
        check_val("byp_rename_ok", rename_ok, 1);
        cycle(1'b1);

        clear_inputs();
        src1_arch[2] = 5'd3;
        #1;
        check_val("r3_map", src1_preg[2], 41);
        check_val("r3_pending", src1_ready[2], 0);
        cycle(1'b1);

        // same-cycle CDB wakeup
        clear_inputs();
        src1_arch[2] = 5'd3;
        cdb_valid = 3'b010; cdb_tag[1] = 6'd41;
        #1;
        check_val("cdb_fwd_ready", src1_ready[2], 1);
        cycle(1'b1);
        clear_inputs();
        src1_arch[2] = 5'd3;
        #1;
        check_val("cdb_ready_kept", src1_ready[2], 1);
        cycle(1'b1);

        // stall when a needed free reg is missing
        clear_inputs();
        dispatch_en = 3'b010; dest_valid = 3'b010; free_reg_valid = 3'b101;
        dest_arch[1] = 5'd9; free_reg[1] = 6'd50;
        #1;
        check_val("stall_rename_ok", rename_ok, 0);
        cycle(1'b1);
        clear_inputs();
        src1_arch[2] = 5'd9; src2_arch[2] = 5'd3;
        #1;
        check_val("stall_r9_map", src1_preg[2], 9);
        check_val("stall_r3_map", src2_preg[2], 41);
        cycle(1'b1);

        // recovery with same-cycle retire
        clear_inputs();
        dispatch_en = 3'b100; dest_valid = 3'b100; free_reg_valid = 3'b111;
        dest_arch[2] = 5'd7; free_reg[2] = 6'd45;
        retire_en = 3'b100; retire_arch[2] = 5'd7; retire_preg[2] = 6'd44;
        bp_recover_en = 1'b1;
        #1;
        check_val("bp_rename_ok", rename_ok, 0);
        cycle(1'b1);
        clear_inputs();
        src1_arch[2] = 5'd7; src2_arch[2] = 5'd3;
        #1;
        check_val("bp_r7_map", src1_preg[2], 44);
        check_val("bp_r7_ready", src1_ready[2], 1);
        check_val("bp_r3_map", src2_preg[2], 3);
        cycle(1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            #1;
            cycle(1'b1);
        end

        // reset mid-stream with traffic active
        rand_inputs();
        reset = 1'b0;
        dispatch_en = 3'b111; dest_valid = 3'b111; free_reg_valid = 3'b111; retire_en = 3'b111;
        #1;
        cycle(1'b1);
        clear_inputs();
        for (int k = 0; k < WAYS; k++) begin
            src1_arch[k] = 5'($urandom_range(1, 31));
            src2_arch[k] = 5'($urandom_range(1, 31));
        end
        #1;
        for (int k = 0; k < WAYS; k++) begin
            check_val($sformatf("mid_rst_s1p[%0d]", k), src1_preg[k], src1_arch[k]);
            check_val($sformatf("mid_rst_s1r[%0d]", k), src1_ready[k], 1);
            check_val($sformatf("mid_rst_s2p[%0d]", k), src2_preg[k], src2_arch[k]);
            check_val($sformatf("mid_rst_s2r[%0d]", k), src2_ready[k], 1);
        end
        cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameter PR_W, default 6, SHALL set physical register tag width (64 PRs).
REQ-002 Parameter ARCH_N, default 32, SHALL set the architectural register count; the arch index is 5 bits.
REQ-003 Parameter WAYS, default 3, SHALL set rename/retire/CDB width; way 2 is oldest, way 0 youngest.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 dispatch_en  in  [2:0]  per-way instruction present at rename.
REQ-007 dest_valid  in  [2:0]  per-way instruction writes a destination.
REQ-008 dest_arch, src1_arch, src2_arch  in  [2:0][4:0]  per-way architectural operands.
REQ-009 free_reg  in  [2:0][PR_W-1:0]  new PRs from freelist, way-aligned.
REQ-010 free_reg_valid  in  [2:0]  free_reg[k] usable.
REQ-011 cdb_valid  in  [2:0] and cdb_tag  in  [2:0][PR_W-1:0]  completing PR tags.
REQ-012 retire_en  in  [2:0], retire_arch  in  [2:0][4:0], retire_preg  in  [2:0][PR_W-1:0]  committing mappings.
REQ-013 bp_recover_en  in  1  mispredict squash.
REQ-014 src1_preg, src2_preg  out  [2:0][PR_W-1:0]  renamed sources.
REQ-015 src1_ready, src2_ready  out  [2:0]  source value available.
REQ-016 told  out  [2:0][PR_W-1:0]  previous mapping of dest_arch[k], for ROB.
REQ-017 rename_ok  out  1  whole group may rename this cycle.

Function
REQ-018 Outputs SHALL be combinational from current state and inputs (zero latency); state updates SHALL be visible the next cycle.
REQ-019 Way k needs a PR iff dispatch_en[k] & dest_valid[k] & dest_arch[k]!=0.
REQ-020 rename_ok SHALL be 1 iff every way needing a PR has free_reg_valid[k]=1 and bp_recover_en=0.
REQ-021 When rename_ok=0, no speculative map or ready-bit rename updates SHALL occur; CDB and retire updates still apply.
REQ-022 Source lookup for way k SHALL bypass from the youngest older way j>k needing a PR with dest_arch[j]==srcX_arch[k], giving free_reg[j], ready=0.
REQ-023 told[k] SHALL apply the same older-way bypass on dest_arch[k]; told of ways not needing a PR SHALL be 0.
REQ-024 Arch register 0 SHALL always map to PR 0, ready=1, and never be written.
REQ-025 Same-cycle CDB match on a non-bypassed source tag SHALL force srcX_ready=1.
REQ-026 Multiple ways writing the same arch reg SHALL leave the youngest way's free_reg in the map.
REQ-027 Renamed PR ready bit SHALL clear next cycle; CDB tag ready bit SHALL set; rename clear wins over CDB for the same PR.
REQ-028 Retire SHALL write retire_preg into the architectural map, oldest first, youngest way winning on conflict.
REQ-029 On bp_recover_en, next-cycle speculative map SHALL equal next-cycle architectural map (including same-cycle retires), all ready bits 1; dispatch ignored.

Reset
REQ-030 On reset=0 at posedge, both maps SHALL set arch i -> PR i and all ready bits 1, overriding all other inputs.
REQ-031 With reset asserted, outputs SHALL reflect reset state from the next cycle: src preg = arch index, ready=1, rename_ok per REQ-020.

Structure
REQ-032 PR_W, ARCH_N, WAYS, preg_t and arch_t SHALL live in the shared processor package.
REQ-033 The architectural (retirement) map SHALL be a sub-module arch_map, exposing its next-state array for recovery.

Verification
REQ-034 Post-reset, way2 src1_arch=5, no dispatch -> src1_preg=5, src1_ready=1.
REQ-035 Way2 dest r3 free 40, way1 src1 r3, way0 dest r3 free 41 -> way1 src1_preg=40 ready=0; told2=3, told0=40; next cycle r3->41.
REQ-036 PR 41 pending, cdb_valid[1]=1 tag 41 same cycle as lookup of r3 -> src_ready=1; ready bit stays 1 next cycle.
REQ-037 Way1 needs PR, free_reg_valid[1]=0 -> rename_ok=0, maps unchanged next cycle.
REQ-038 Rename r7->45, retire r7->44 with bp_recover_en same cycle -> next cycle r7 maps 44, ready=1.
REQ-039 reset=0 mid-stream with dispatch and retire active -> next cycle all maps identity, all ready.
